// File: rtl/estagio_writeback.sv
// Write-back stage of the MIPS datapath: selects ALU, load or link result and drives the register bank.
// Optional forwarding outputs are enabled with the WB_BYPASS_EN macro.
module estagio_writeback #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TIMEOUT_W   = 4
) (
   input  logic        wb_in_clk,
   input  logic        wb_in_rst,
   input  logic        wb_in_valid,
   output logic        wb_out_ready,
   input  logic        wb_in_reg_we,
   input  logic [4:0]  wb_in_rd,
   input  logic [1:0]  wb_in_sel,
   input  logic [2:0]  wb_in_ld_type,
   input  logic [31:0] wb_in_alu,
   input  logic [31:0] wb_in_link,
   input  logic        wb_in_mem_valid,
   input  logic [31:0] wb_in_mem_data,
   output logic [4:0]  wb_out_rd,
   output logic [31:0] wb_out_data,
   output logic        wb_out_w_en,
   output logic        wb_out_err
`ifdef WB_BYPASS_EN
   ,
   output logic        wb_out_fwd_valid,
   output logic [4:0]  wb_out_fwd_rd,
   output logic [31:0] wb_out_fwd_data
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

   localparam logic [TIMEOUT_W-1:0] CNT_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_W-1:0] CNT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

   // Big-endian byte/half lane selection with sign or zero extension.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [2:0]  ld_type,
                                                input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[15:0] : word[31:16];
      case (ld_type)
         LD_LH:   load_extract = {{16{h[15]}}, h};
         LD_LHU:  load_extract = {16'h0000, h};
         LD_LB:   load_extract = {{24{b[7]}}, b};
         LD_LBU:  load_extract = {24'h00_0000, b};
         default: load_extract = word;
      endcase
   endfunction

   logic [1:0]           state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [4:0]           cap_rd_q, cap_rd_d;
   logic                 cap_we_q, cap_we_d;
   logic [2:0]           cap_ld_q, cap_ld_d;
   logic [1:0]           cap_off_q, cap_off_d;
   logic [4:0]           rd_q, rd_d;
   logic [31:0]          data_q, data_d;
   logic                 w_en_q, w_en_d;
   logic                 err_q, err_d;
   logic                 accept_s;
   logic [TIMEOUT_W-1:0] cnt_inc_s;

   assign wb_out_ready = (state_q != ST_WAIT);
   assign accept_s     = wb_in_valid & wb_out_ready;
   assign cnt_inc_s    = cnt_q + CNT_ONE;
   assign wb_out_rd    = rd_q;
   assign wb_out_data  = data_q;
   assign wb_out_w_en  = w_en_q;
   assign wb_out_err   = err_q;

   // Next-state, capture and output selection; rd/data only move on a real write.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_rd_d  = cap_rd_q;
      cap_we_d  = cap_we_q;
      cap_ld_d  = cap_ld_q;
      cap_off_d = cap_off_q;
      rd_d      = rd_q;
      data_d    = data_q;
      w_en_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE, ST_WRITE: begin
            if (accept_s) begin
               cap_rd_d  = wb_in_rd;
               cap_we_d  = wb_in_reg_we;
               cap_ld_d  = wb_in_ld_type;
               cap_off_d = wb_in_alu[1:0];
               if (wb_in_sel == SEL_LOAD) begin
                  state_d = ST_WAIT;
                  cnt_d   = {TIMEOUT_W{1'b0}};
               end else begin
                  state_d = ST_WRITE;
                  w_en_d  = wb_in_reg_we & (wb_in_rd != 5'd0);
                  if (w_en_d) begin
                     rd_d   = wb_in_rd;
                     data_d = (wb_in_sel == SEL_LINK) ? wb_in_link : wb_in_alu;
                  end else begin
                     rd_d   = rd_q;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wb_in_mem_valid) begin
               state_d = ST_WRITE;
               w_en_d  = cap_we_q & (cap_rd_q != 5'd0);
               if (w_en_d) begin
                  rd_d   = cap_rd_q;
                  data_d = load_extract(wb_in_mem_data, cap_ld_q, cap_off_q);
               end else begin
                  rd_d   = rd_q;
               end
            end else if (cnt_inc_s == CNT_LIMIT) begin
               state_d = ST_IDLE;
               cnt_d   = cnt_inc_s;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_inc_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stage state and registered bank-facing outputs.
   always_ff @(posedge wb_in_clk or negedge wb_in_rst) begin
      if (!wb_in_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {TIMEOUT_W{1'b0}};
         cap_rd_q  <= 5'd0;
         cap_we_q  <= 1'b0;
         cap_ld_q  <= 3'd0;
         cap_off_q <= 2'd0;
         rd_q      <= 5'd0;
         data_q    <= 32'd0;
         w_en_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_rd_q  <= cap_rd_d;
         cap_we_q  <= cap_we_d;
         cap_ld_q  <= cap_ld_d;
         cap_off_q <= cap_off_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         w_en_q    <= w_en_d;
         err_q     <= err_d;
      end
   end

`ifdef WB_BYPASS_EN
   logic        fwd_valid_q;
   logic [4:0]  fwd_rd_q;
   logic [31:0] fwd_data_q;

   assign wb_out_fwd_valid = fwd_valid_q;
   assign wb_out_fwd_rd    = fwd_rd_q;
   assign wb_out_fwd_data  = fwd_data_q;

   // Forwarding copy, loaded alongside each write pulse and held until the next one.
   always_ff @(posedge wb_in_clk or negedge wb_in_rst) begin
      if (!wb_in_rst) begin
         fwd_valid_q <= 1'b0;
         fwd_rd_q    <= 5'd0;
         fwd_data_q  <= 32'd0;
      end else if (w_en_d) begin
         fwd_valid_q <= 1'b1;
         fwd_rd_q    <= rd_d;
         fwd_data_q  <= data_d;
      end else begin
         fwd_valid_q <= fwd_valid_q;
         fwd_rd_q    <= fwd_rd_q;
         fwd_data_q  <= fwd_data_q;
      end
   end
`endif

endmodule

// File: tb/tb_estagio_writeback.sv
// Directed bench for estagio_writeback with a write scoreboard; define WB_BYPASS_EN to also check forwarding outputs.
module tb_estagio_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, ready, reg_we, mem_valid;
   logic [4:0]  rd;
   logic [1:0]  sel;
   logic [2:0]  ld_type;
   logic [31:0] alu, link, mem_data;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic        w_en, err;
`ifdef WB_BYPASS_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [36:0] sb_q[$];

   always #5 clk = ~clk;

   estagio_writeback dut (
      .wb_in_clk       (clk),
      .wb_in_rst       (rst_n),
      .wb_in_valid     (valid),
      .wb_out_ready    (ready),
      .wb_in_reg_we    (reg_we),
      .wb_in_rd        (rd),
      .wb_in_sel       (sel),
      .wb_in_ld_type   (ld_type),
      .wb_in_alu       (alu),
      .wb_in_link      (link),
      .wb_in_mem_valid (mem_valid),
      .wb_in_mem_data  (mem_data),
      .wb_out_rd       (out_rd),
      .wb_out_data     (out_data),
      .wb_out_w_en     (w_en),
      .wb_out_err      (err)
`ifdef WB_BYPASS_EN
      ,
      .wb_out_fwd_valid(fwd_valid),
      .wb_out_fwd_rd   (fwd_rd),
      .wb_out_fwd_data (fwd_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] r, input logic [1:0] s,
                        input logic [2:0] ld, input logic [31:0] a, input logic [31:0] l);
      valid = v; reg_we = we; rd = r; sel = s; ld_type = ld; alu = a; link = l;
      if (v && we && (r != 5'd0) && (s != 2'b01))
         sb_q.push_back({r, (s == 2'b10) ? l : a});
   endtask

   task automatic do_load(input logic [4:0] r, input logic [2:0] ld, input logic [31:0] a,
                          input logic [31:0] md, input int waits, input logic [31:0] exp);
      drive(1'b1, 1'b1, r, 2'b01, ld, a, 32'h0);
      sb_q.push_back({r, exp});
      step();
      valid = 1'b0;
      for (int i = 0; i < waits; i++) begin
         chk("ld_wait_ready", {31'd0, ready}, 32'd0);
         chk("ld_wait_wen", {31'd0, w_en}, 32'd0);
         step();
      end
      chk("ld_ready_low", {31'd0, ready}, 32'd0);
      mem_valid = 1'b1; mem_data = md;
      step();
      mem_valid = 1'b0;
      chk("ld_wen", {31'd0, w_en}, 32'd1);
      chk("ld_data", out_data, exp);
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (w_en) begin
         if (sb_q.size() == 0) begin
            chk("spurious_wen", 32'd1, 32'd0);
         end else begin
            logic [36:0] e;
            e = sb_q.pop_front();
            chk("sb_rd", {27'd0, out_rd}, {27'd0, e[36:32]});
            chk("sb_data", out_data, e[31:0]);
         end
      end
   end

   initial begin
      rst_n = 1'b0; mem_valid = 1'b0; mem_data = 32'h0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0);
      step(); step();
      chk("rst_wen", {31'd0, w_en}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
`ifdef WB_BYPASS_EN
      chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // ALU path, with stray mem_valid in IDLE that must be ignored
      mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
      drive(1'b1, 1'b1, 5'd8, 2'b00, 3'd0, 32'h0000_1234, 32'h0);
      step();
      mem_valid = 1'b0; valid = 1'b0;
      chk("alu_wen", {31'd0, w_en}, 32'd1);
      chk("alu_rd", {27'd0, out_rd}, 32'd8);
      chk("alu_data", out_data, 32'h0000_1234);
      step();
      chk("alu_wen_drop", {31'd0, w_en}, 32'd0);
      chk("alu_data_hold", out_data, 32'h0000_1234);

      // Loads: LB sign with memory 3 cycles after accept, then lane/extension variants
      do_load(5'd9, 3'b011, 32'h0000_0101, 32'h1180_2233, 2, 32'hFFFF_FF80);
      step();
      chk("after_ld_idle_wen", {31'd0, w_en}, 32'd0);
      chk("after_ld_ready", {31'd0, ready}, 32'd1);
      do_load(5'd10, 3'b010, 32'h0000_0002, 32'hAAAA_8001, 0, 32'h0000_8001);
      do_load(5'd11, 3'b000, 32'h0000_0003, 32'hAAAA_8001, 1, 32'hAAAA_8001);
      do_load(5'd12, 3'b001, 32'h0000_0001, 32'hFEDC_0000, 0, 32'hFFFF_FEDC);
      do_load(5'd13, 3'b100, 32'h0000_0003, 32'h0000_0080, 0, 32'h0000_0080);
      do_load(5'd14, 3'b111, 32'h0000_0002, 32'h1234_5678, 0, 32'h1234_5678);
      valid = 1'b0;
      step();

      // Zero guard, reg_we=0, link select and reserved select
      drive(1'b1, 1'b1, 5'd0, 2'b00, 3'd0, 32'h0000_DEAD, 32'h0);
      step();
      chk("zero_wen", {31'd0, w_en}, 32'd0);
      chk("zero_data_hold", out_data, 32'h1234_5678);
      drive(1'b1, 1'b0, 5'd7, 2'b00, 3'd0, 32'h0000_0777, 32'h0);
      step();
      chk("nowe_wen", {31'd0, w_en}, 32'd0);
      drive(1'b1, 1'b1, 5'd31, 2'b10, 3'd0, 32'h0000_5555, 32'h0040_0010);
      step();
      chk("link_wen", {31'd0, w_en}, 32'd1);
      chk("link_data", out_data, 32'h0040_0010);
`ifdef WB_BYPASS_EN
      chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
      chk("fwd_rd", {27'd0, fwd_rd}, 32'd31);
      chk("fwd_data", fwd_data, 32'h0040_0010);
`endif
      drive(1'b1, 1'b1, 5'd5, 2'b11, 3'd0, 32'h0000_0077, 32'h0040_0020);
      step();
      chk("rsv_data", out_data, 32'h0000_0077);
      valid = 1'b0;
      step();
`ifdef WB_BYPASS_EN
      chk("fwd_hold", fwd_data, 32'h0000_0077);
`endif

      // Timeout: 15 waiting cycles then one err pulse, no write
      drive(1'b1, 1'b1, 5'd20, 2'b01, 3'd0, 32'h0, 32'h0);
      step();
      valid = 1'b0;
      for (int i = 1; i < 15; i++) begin
         chk("to_ready_low", {31'd0, ready}, 32'd0);
         chk("to_err_low", {31'd0, err}, 32'd0);
         step();
      end
      chk("to_ready_last", {31'd0, ready}, 32'd0);
      step();
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_wen", {31'd0, w_en}, 32'd0);
      chk("to_ready_back", {31'd0, ready}, 32'd1);
      step();
      chk("to_err_once", {31'd0, err}, 32'd0);

      // Back-to-back ALU writes
      drive(1'b1, 1'b1, 5'd1, 2'b00, 3'd0, 32'h0000_0A01, 32'h0);
      step();
      chk("b2b_wen1", {31'd0, w_en}, 32'd1);
      drive(1'b1, 1'b1, 5'd2, 2'b00, 3'd0, 32'h0000_0A02, 32'h0);
      step();
      chk("b2b_wen2", {31'd0, w_en}, 32'd1);
      drive(1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'h0000_0A03, 32'h0);
      step();
      chk("b2b_wen3", {31'd0, w_en}, 32'd1);
      chk("b2b_data3", out_data, 32'h0000_0A03);
      valid = 1'b0;
      step();
      chk("b2b_end", {31'd0, w_en}, 32'd0);

      // Reset while waiting for memory discards the load
      drive(1'b1, 1'b1, 5'd21, 2'b01, 3'd0, 32'h0, 32'h0);
      step();
      valid = 1'b0;
      chk("rw_ready_low", {31'd0, ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_ready_rst", {31'd0, ready}, 32'd1);
      chk("rw_data_rst", out_data, 32'd0);
`ifdef WB_BYPASS_EN
      chk("rw_fwd_clr", {31'd0, fwd_valid}, 32'd0);
`endif
      mem_valid = 1'b1; mem_data = 32'h5555_AAAA;
      step();
      rst_n = 1'b1;
      step();
      chk("rw_wen", {31'd0, w_en}, 32'd0);
      chk("rw_err", {31'd0, err}, 32'd0);
      step();
      chk("rw_wen2", {31'd0, w_en}, 32'd0);
      mem_valid = 1'b0;
      step(); step();
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
